// File: rtl/arm_master_bridge.sv
// ARM lightweight-master to GPStudio parameter-bus bridge.
// Window decode, byte-to-word addressing, single-cycle strobes, sticky error.
module arm_master_bridge #(
    parameter int                           MASTER_ADDR_WIDTH = 32,
    parameter int                           SLAVE_ADDR_WIDTH  = 4,
    parameter logic [MASTER_ADDR_WIDTH-1:0] BASE_ADDR         = '0,
    parameter int                           READ_LATENCY      = 1,
    parameter logic [31:0]                  MISS_DATA         = 32'hDEADBEEF
) (
    input  logic                         clk_proc,
    input  logic                         reset_n,
    input  logic [MASTER_ADDR_WIDTH-1:0] master_addr_i,
    input  logic                         master_wr_i,
    input  logic                         master_rd_i,
    input  logic [31:0]                  master_datawr_i,
    output logic [31:0]                  master_datard_o,
    output logic                         master_waitreq_o,
    output logic [SLAVE_ADDR_WIDTH-1:0]  bus_addr_o,
    output logic                         bus_wr_o,
    output logic                         bus_rd_o,
    output logic [31:0]                  bus_datawr_o,
    input  logic [31:0]                  bus_datard_i,
    output logic                         err_o,
    input  logic                         err_clear_i
);

    localparam int          LSB = SLAVE_ADDR_WIDTH + 2;
    localparam logic [3:0]  RL  = 4'(READ_LATENCY);

    typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, ACK} state_e;

    state_e                      state_q, state_d;
    logic [3:0]                  cnt_q, cnt_d;
    logic                        waitreq_q, waitreq_d;
    logic [31:0]                 datard_q, datard_d;
    logic [SLAVE_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                        wr_q, wr_d;
    logic                        rd_q, rd_d;
    logic [31:0]                 datawr_q, datawr_d;
    logic                        err_q, err_d;
    logic                        err_set;
    logic                        hit;

    assign hit = (master_addr_i[MASTER_ADDR_WIDTH-1:LSB] ==
                  BASE_ADDR[MASTER_ADDR_WIDTH-1:LSB]) &&
                 (master_addr_i[1:0] == 2'b00);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        waitreq_d = 1'b1;
        datard_d  = datard_q;
        addr_d    = addr_q;
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        datawr_d  = datawr_q;
        err_set   = 1'b0;
        case (state_q)
            IDLE: begin
                if (master_wr_i || master_rd_i) begin
                    if (!hit) begin
                        // Misses complete immediately without a bus strobe
                        err_set   = 1'b1;
                        waitreq_d = 1'b0;
                        state_d   = ACK;
                        if (!master_wr_i) datard_d = MISS_DATA;
                    end else if (master_wr_i) begin
                        addr_d   = master_addr_i[LSB-1:2];
                        datawr_d = master_datawr_i;
                        wr_d     = 1'b1;
                        state_d  = WRITE;
                    end else begin
                        addr_d  = master_addr_i[LSB-1:2];
                        rd_d    = 1'b1;
                        cnt_d   = RL;
                        state_d = READ_WAIT;
                    end
                end
            end
            WRITE: begin
                waitreq_d = 1'b0;
                state_d   = ACK;
            end
            READ_WAIT: begin
                if (cnt_q == 4'd0) begin
                    datard_d  = bus_datard_i;
                    waitreq_d = 1'b0;
                    state_d   = ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        err_d = err_set | (err_q & ~err_clear_i);
    end

    always_ff @(posedge clk_proc or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            waitreq_q <= 1'b1;
            datard_q  <= 32'd0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            datawr_q  <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            waitreq_q <= waitreq_d;
            datard_q  <= datard_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            datawr_q  <= datawr_d;
            err_q     <= err_d;
        end
    end

    assign master_waitreq_o = waitreq_q;
    assign master_datard_o  = datard_q;
    assign bus_addr_o       = addr_q;
    assign bus_wr_o         = wr_q;
    assign bus_rd_o         = rd_q;
    assign bus_datawr_o     = datawr_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_arm_master_bridge.sv
// Bench for arm_master_bridge: transaction-level timeline model,
// per-cycle output compare, directed cases then random traffic.
module tb_arm_master_bridge;

    localparam int L = 2;
    localparam logic [31:0] MISS = 32'hDEADBEEF;

    logic        clk_proc = 1'b0;
    logic        reset_n;
    logic [31:0] master_addr_i;
    logic        master_wr_i;
    logic        master_rd_i;
    logic [31:0] master_datawr_i;
    logic [31:0] master_datard_o;
    logic        master_waitreq_o;
    logic [3:0]  bus_addr_o;
    logic        bus_wr_o;
    logic        bus_rd_o;
    logic [31:0] bus_datawr_o;
    logic [31:0] bus_datard_i;
    logic        err_o;
    logic        err_clear_i;

    arm_master_bridge #(
        .MASTER_ADDR_WIDTH(32),
        .SLAVE_ADDR_WIDTH (4),
        .BASE_ADDR        (32'h0),
        .READ_LATENCY     (L),
        .MISS_DATA        (MISS)
    ) dut (
        .clk_proc        (clk_proc),
        .reset_n         (reset_n),
        .master_addr_i   (master_addr_i),
        .master_wr_i     (master_wr_i),
        .master_rd_i     (master_rd_i),
        .master_datawr_i (master_datawr_i),
        .master_datard_o (master_datard_o),
        .master_waitreq_o(master_waitreq_o),
        .bus_addr_o      (bus_addr_o),
        .bus_wr_o        (bus_wr_o),
        .bus_rd_o        (bus_rd_o),
        .bus_datawr_o    (bus_datawr_o),
        .bus_datard_i    (bus_datard_i),
        .err_o           (err_o),
        .err_clear_i     (err_clear_i)
    );

    always #5 clk_proc = ~clk_proc;

    int vectors = 0;
    int miscompares = 0;

    logic        exp_wait, exp_wr, exp_rd, exp_err;
    logic [31:0] exp_datard, exp_data;
    logic [3:0]  exp_addr;
    bit          chk_en = 1'b0;
    bit          miss_now = 1'b0;
    bit          clr_rand_en = 1'b0;

    always @(negedge clk_proc) begin
        if (chk_en) begin
            vectors++;
            if (master_waitreq_o !== exp_wait || master_datard_o !== exp_datard ||
                bus_addr_o !== exp_addr || bus_wr_o !== exp_wr ||
                bus_rd_o !== exp_rd || bus_datawr_o !== exp_data ||
                err_o !== exp_err) begin
                miscompares++;
                $display("FAIL cycle t=%0t got wait=%b rdat=%h addr=%h wr=%b rd=%b wdat=%h err=%b required wait=%b rdat=%h addr=%h wr=%b rd=%b wdat=%h err=%b",
                         $time, master_waitreq_o, master_datard_o, bus_addr_o,
                         bus_wr_o, bus_rd_o, bus_datawr_o, err_o,
                         exp_wait, exp_datard, exp_addr, exp_wr, exp_rd,
                         exp_data, exp_err);
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] got,
                       input logic [31:0] req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", nm, got, req);
        end
    endtask

    task automatic exp_reset();
        exp_wait   = 1'b1;
        exp_datard = 32'd0;
        exp_addr   = 4'd0;
        exp_wr     = 1'b0;
        exp_rd     = 1'b0;
        exp_data   = 32'd0;
        exp_err    = 1'b0;
    endtask

    // Advance one cycle; error flag follows set-wins-over-clear rule
    task automatic step();
        logic nerr;
        nerr = miss_now | (exp_err & ~err_clear_i);
        if (!reset_n) nerr = 1'b0;
        @(posedge clk_proc);
        #1;
        exp_err      = nerr;
        miss_now     = 1'b0;
        exp_wr       = 1'b0;
        exp_rd       = 1'b0;
        exp_wait     = 1'b1;
        err_clear_i  = clr_rand_en ? ($urandom % 6 == 0) : 1'b0;
        bus_datard_i = $urandom;
    endtask

    // One master transaction starting in the current idle cycle
    task automatic txn(input logic wr, input logic rd,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] rdat, input logic clr0);
        bit hit;
        hit = ((addr >> 6) == 0) && (addr % 4 == 0);
        master_wr_i     = wr;
        master_rd_i     = rd;
        master_addr_i   = addr;
        master_datawr_i = data;
        err_clear_i     = clr0;
        if (!hit) begin
            miss_now = 1'b1;
            step();
            exp_wait = 1'b0;
            if (!wr) exp_datard = MISS;
        end else if (wr) begin
            step();
            exp_wr   = 1'b1;
            exp_addr = 4'((addr >> 2) % 16);
            exp_data = data;
            step();
            exp_wait = 1'b0;
        end else begin
            step();
            exp_rd   = 1'b1;
            exp_addr = 4'((addr >> 2) % 16);
            for (int k = 0; k < L; k++) step();
            bus_datard_i = rdat;
            step();
            exp_wait   = 1'b0;
            exp_datard = rdat;
        end
        master_wr_i = 1'b0;
        master_rd_i = 1'b0;
        step();
    endtask

    initial begin
        logic        w, r;
        logic [31:0] a;
        int          sel;
        reset_n         = 1'b0;
        master_addr_i   = 32'd0;
        master_wr_i     = 1'b0;
        master_rd_i     = 1'b0;
        master_datawr_i = 32'd0;
        bus_datard_i    = 32'd0;
        err_clear_i     = 1'b0;
        exp_reset();
        chk_en = 1'b1;
        step();
        step();
        lit("reset_waitreq", 32'(master_waitreq_o), 32'd1);
        lit("reset_datard", master_datard_o, 32'd0);
        lit("reset_err", 32'(err_o), 32'd0);
        reset_n = 1'b1;
        step();

        txn(1'b1, 1'b0, 32'h0C, 32'h12345678, 32'd0, 1'b0);
        lit("wr_bus_addr", 32'(bus_addr_o), 32'd3);
        lit("wr_bus_data", bus_datawr_o, 32'h12345678);

        txn(1'b0, 1'b1, 32'h04, 32'd0, 32'hCAFEF00D, 1'b0);
        lit("rd_data", master_datard_o, 32'hCAFEF00D);

        txn(1'b0, 1'b1, 32'h1000, 32'd0, 32'd0, 1'b0);
        lit("miss_rd_data", master_datard_o, 32'hDEADBEEF);
        lit("miss_err", 32'(err_o), 32'd1);

        txn(1'b1, 1'b0, 32'h02, 32'h55, 32'd0, 1'b0);
        lit("miss_wr_keeps_data", master_datard_o, 32'hDEADBEEF);

        txn(1'b0, 1'b1, 32'h41, 32'd0, 32'd0, 1'b1);
        lit("set_wins_clear", 32'(err_o), 32'd1);
        err_clear_i = 1'b1;
        step();
        lit("err_cleared", 32'(err_o), 32'd0);

        txn(1'b1, 1'b1, 32'h08, 32'hA5A5A5A5, 32'd0, 1'b0);
        lit("wr_prio_addr", 32'(bus_addr_o), 32'd2);

        // Reset asserted while the read strobe is high
        master_rd_i   = 1'b1;
        master_addr_i = 32'h10;
        step();
        exp_rd   = 1'b1;
        exp_addr = 4'd4;
        #2;
        reset_n     = 1'b0;
        master_rd_i = 1'b0;
        exp_reset();
        #1;
        lit("rst_rd_drop", 32'(bus_rd_o), 32'd0);
        lit("rst_waitreq", 32'(master_waitreq_o), 32'd1);
        step();
        step();
        reset_n = 1'b1;
        step();
        step();
        txn(1'b0, 1'b1, 32'h14, 32'd0, 32'h13572468, 1'b0);
        lit("post_rst_rd", master_datard_o, 32'h13572468);

        clr_rand_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            w   = 1'($urandom % 2);
            r   = w ? 1'($urandom % 2) : 1'b1;
            sel = int'($urandom % 8);
            if (sel < 5)      a = ($urandom % 64) & ~32'd3;
            else if (sel < 6) a = $urandom % 64;
            else              a = $urandom;
            txn(w, r, a, $urandom, $urandom, 1'($urandom % 5 == 0));
            for (int g = 0; g < int'($urandom % 3); g++) step();
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/arm_master_bridge.md
# arm_master_bridge

Bridges the ARM HPS lightweight master port (Avalon-style address/read/write/waitrequest) onto the GPStudio parameter bus that feeds block register banks. Sits directly downstream of the ARM wrapper's master interface: decodes a base window, converts byte addresses to word indices, and issues single-cycle bus strobes. Reads are answered after a fixed parameter-bus read latency. Out-of-window or misaligned accesses complete without touching the bus and raise a sticky error flag.

## Interface
- MASTER_ADDR_WIDTH, 32, width of master byte address
- SLAVE_ADDR_WIDTH, 4, parameter-bus word-address width (window = 2^(SLAVE_ADDR_WIDTH+2) bytes)
- BASE_ADDR, 0, window base; only bits [MASTER_ADDR_WIDTH-1:SLAVE_ADDR_WIDTH+2] compared
- READ_LATENCY, 1, cycles from bus_rd_o strobe to valid bus_datard_i (legal 0..15)
- MISS_DATA, 32'hDEADBEEF, read data returned on error accesses

- clk_proc  in  1  processing clock
- reset_n  in  1  asynchronous reset, active low
- master_addr_i  in  MASTER_ADDR_WIDTH  byte address from ARM master
- master_wr_i  in  1  write request, held until waitreq low
- master_rd_i  in  1  read request, held until waitreq low
- master_datawr_i  in  32  write data
- master_datard_o  out  32  read data, valid in ACK cycle
- master_waitreq_o  out  1  low for exactly the completing cycle
- bus_addr_o  out  SLAVE_ADDR_WIDTH  word address = master_addr_i[SLAVE_ADDR_WIDTH+1:2]
- bus_wr_o  out  1  one-cycle write strobe
- bus_rd_o  out  1  one-cycle read strobe
- bus_datawr_o  out  32  write data, valid with bus_wr_o
- bus_datard_i  in  32  read data from parameter bus
- err_o  out  1  sticky access-error flag
- err_clear_i  in  1  clears err_o

## Operation
- All outputs registered. Reset values: master_waitreq_o=1, master_datard_o=0, bus_addr_o=0, bus_wr_o=0, bus_rd_o=0, bus_datawr_o=0, err_o=0, FSM=IDLE, latency counter=0.
- Hit = upper address bits equal BASE_ADDR upper bits AND master_addr_i[1:0]==0.
- FSM states IDLE, WRITE, READ_WAIT, ACK:
  - IDLE: wr_i has priority over rd_i when both high. wr hit -> latch addr/data, WRITE. rd hit -> latch addr, READ_WAIT, counter=READ_LATENCY. Any miss -> err set, datard_o=MISS_DATA on reads (unchanged on writes), ACK.
  - WRITE: bus_wr_o=1 this cycle only -> ACK.
  - READ_WAIT: bus_rd_o=1 in first cycle only; counter decrements each cycle; when counter==0 sample bus_datard_i into master_datard_o -> ACK.
  - ACK: master_waitreq_o=0 for this one cycle -> IDLE.
- master_waitreq_o high in IDLE, WRITE, READ_WAIT; idle-state waitreq high is legal since no transfer completes.
- A request still high in IDLE after ACK is a new transaction (master drives back-to-back).
- master_datard_o holds last read value until next read completes.
- err_o: set on any miss; cleared by err_clear_i; set and clear in same cycle -> set wins.
- Reset assertion mid-transaction: immediate return to reset values, strobes drop asynchronously, no partial bus access completes afterward.

## Timing
- Request sampled at edge ending cycle 0 (IDLE).
- Write hit: bus_wr_o high cycle 1, waitreq low cycle 2; 3 cycles total.
- Read hit: bus_rd_o high cycle 1; bus_datard_i sampled at edge ending cycle 1+READ_LATENCY; waitreq low and data valid cycle 2+READ_LATENCY.
- Miss: waitreq low cycle 1; no bus strobe ever asserted.
- Maximum throughput: one transaction per 3 cycles (writes), 3+READ_LATENCY (reads).

## Test plan
- Reset: hold reset_n low -> waitreq_o=1, all bus strobes 0, err_o=0, datard_o=0.
- Write hit: BASE_ADDR=0, wr addr 0x0C data 0x12345678 -> bus_wr_o one cycle 1, bus_addr_o=3, bus_datawr_o=0x12345678, waitreq low cycle 2.
- Read hit, READ_LATENCY=2: rd addr 0x04, bus returns 0xCAFEF00D at cycle 3 -> bus_rd_o only cycle 1, datard_o=0xCAFEF00D with waitreq low cycle 4.
- Miss/misaligned: rd addr 0x1000 then wr addr 0x02 -> no strobes, first returns 0xDEADBEEF cycle 1, err_o=1; err_clear_i pulse concurrent with new miss -> err_o stays 1.
- Simultaneous wr and rd, addr 0x08 -> only bus_wr_o asserted, bus_rd_o stays 0.
- Reset during READ_WAIT (READ_LATENCY=5, reset at cycle 3) -> outputs at reset values immediately, no ACK, next read after reset completes normally.
